reg_apb2native_if: RTL and testbench

REG_APB2NATIVE_IF -- requirements
Module: reg_apb2native_if

---
 rtl/reg_apb2native_if.sv | 109 ++++++++++
 tb/tb_reg_apb2native_if.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_apb2native_if.sv
// APB slave to native register-bus bridge: one outstanding transfer, single-cycle
// request strobe, optional timeout that answers the APB side with an error.
module reg_apb2native_if #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic                  req_vld,
    input  logic                  ack_vld,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  err
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           r_state;
    logic             r_wr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_timeout;

    // The current cycle counts as a waiting cycle; an ack in that same cycle takes precedence.
    assign w_cntNext = r_cnt + 1'b1;
    assign w_timeout = TO_EN && !ack_vld && (w_cntNext == TO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wr    <= 1'b0;
            r_cnt   <= '0;
            req_vld <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            addr    <= '0;
            wr_data <= '0;
            prdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (psel && !penable) begin
                        addr    <= paddr;
                        wr_data <= pwdata;
                        r_wr    <= pwrite;
                        req_vld <= 1'b1;
                        wr_en   <= pwrite;
                        rd_en   <= !pwrite;
                        r_cnt   <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    req_vld <= 1'b0;
                    wr_en   <= 1'b0;
                    rd_en   <= 1'b0;
                    if (ack_vld) begin
                        pready  <= 1'b1;
                        pslverr <= err;
                        prdata  <= r_wr ? '0 : rd_data;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        pready  <= 1'b1;
                        pslverr <= 1'b1;
                        prdata  <= '0;
                        r_state <= S_RESP;
                    end else begin
                        if (TO_EN) begin
                            r_cnt <= w_cntNext;
                        end
                        r_state <= S_WAIT;
                    end
                end
                S_RESP: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_apb2native_if.sv
// Randomized scoreboard bench for reg_apb2native_if: an APB master task pushes the
// expected native request and APB response; negedge monitors pop and compare.
module tb_reg_apb2native_if;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
    } req_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          e;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready, pslverr;
    logic [DW-1:0] prdata;
    logic          req_vld, ack_vld, wr_en, rd_en, err;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data, rd_data;

    req_t  reqQ[$];
    resp_t respQ[$];
    int    compared   = 0;
    int    mismatched = 0;

    reg_apb2native_if #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .pready (pready),
        .prdata (prdata),
        .pslverr(pslverr),
        .req_vld(req_vld),
        .ack_vld(ack_vld),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_vld"}, 64'(req_vld), 64'd0);
        checkOutput({tag, "_wr_en"},   64'(wr_en),   64'd0);
        checkOutput({tag, "_rd_en"},   64'(rd_en),   64'd0);
        checkOutput({tag, "_pready"},  64'(pready),  64'd0);
        checkOutput({tag, "_pslverr"}, 64'(pslverr), 64'd0);
        checkOutput({tag, "_addr"},    64'(addr),    64'd0);
        checkOutput({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        checkOutput({tag, "_prdata"},  64'(prdata),  64'd0);
    endtask

    // Reference rule: ack on waiting cycle (delay+1) wins if it is within the TO budget;
    // otherwise the bridge answers with an error and zero data after TO waiting cycles.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input int delay, input logic [DW-1:0] rdd, input logic e,
                                 input bit dropPsel, input bit lateAck);
        bit    timedOut;
        int    expLat;
        int    cyc;
        int    reqSeen;
        bit    done;
        req_t  rq;
        resp_t rs;
        timedOut = (delay < 0) || (delay >= TO);
        rq.a = a; rq.d = d; rq.w = wr;
        rs.d = (timedOut || wr) ? '0 : rdd;
        rs.e = timedOut ? 1'b1 : e;
        reqQ.push_back(rq);
        respQ.push_back(rs);
        expLat = timedOut ? TO + 1 : delay + 2;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 0; reqSeen = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            ack_vld = (cyc == delay);
            rd_data = (cyc == delay) ? rdd : $urandom;
            err     = (cyc == delay) ? e : 1'($urandom_range(0, 1));
            if (dropPsel && cyc >= 1) begin
                psel = 1'b0; penable = 1'b0;
            end
            @(negedge clk);
            if (req_vld) reqSeen++;
            if (pready) begin
                done = 1'b1;
                checkOutput("pready_latency", 64'(cyc + 1), 64'(expLat));
            end
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("pready_seen", 64'(done), 64'd1);
        checkOutput("req_vld_pulses", 64'(reqSeen), 64'd1);
        ack_vld = 1'b0; psel = 1'b0; penable = 1'b0;
        if (lateAck) begin
            ack_vld = 1'b1; err = 1'b1; rd_data = $urandom;
            @(posedge clk); #1;
            ack_vld = 1'b0;
        end
    endtask

    task automatic resetMidTransfer();
        req_t rq;
        rq.a = 64'h55; rq.d = 32'hDEADBEEF; rq.w = 1'b1;
        reqQ.push_back(rq);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 64'h55; pwdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        penable = 1'b1; ack_vld = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #1 rst_n = 1'b0;
        #1 checkResetOutputs("reset_mid");
        psel = 1'b0; penable = 1'b0;
        ack_vld = 1'b1; rd_data = $urandom; err = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ack_vld = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (pready) begin
            if (respQ.size() == 0) begin
                checkOutput("pready_unexpected", 64'd1, 64'd0);
            end else begin
                resp_t r;
                r = respQ.pop_front();
                checkOutput("prdata", 64'(prdata), 64'(r.d));
                checkOutput("pslverr", 64'(pslverr), 64'(r.e));
            end
        end else begin
            checkOutput("pslverr_idle", 64'(pslverr), 64'd0);
        end
    end

    always @(negedge clk) begin
        if (req_vld) begin
            if (reqQ.size() == 0) begin
                checkOutput("req_vld_unexpected", 64'd1, 64'd0);
            end else begin
                req_t q;
                q = reqQ.pop_front();
                checkOutput("addr", addr, q.a);
                checkOutput("wr_data", 64'(wr_data), 64'(q.d));
                checkOutput("wr_en", 64'(wr_en), 64'(q.w));
                checkOutput("rd_en", 64'(rd_en), 64'(!q.w));
            end
        end else begin
            checkOutput("wr_en_idle", 64'(wr_en), 64'd0);
            checkOutput("rd_en_idle", 64'(rd_en), 64'd0);
        end
    end

    initial begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; ack_vld = 1'b0; rd_data = '0; err = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkResetOutputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Access phase without prior setup must be ignored.
        psel = 1'b1; penable = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        psel = 1'b0; penable = 1'b0;

        applyStimulus(1'b1, 64'h10, 32'hA5A5A5A5, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("addr_hold", addr, 64'h10);
        checkOutput("wr_data_hold", 64'(wr_data), 64'hA5A5A5A5);
        applyStimulus(1'b0, 64'h20, 32'h0, 3, 32'h12345678, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h30, 32'h0, -1, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 64'h40, 32'h0, 3, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h44, 32'h0, 4, 32'h0BADF00D, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h50, 32'h11111111, 1, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h54, 32'h22222222, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h58, 32'h0, 2, 32'h77777777, 1'b0, 1'b1, 1'b0);
        resetMidTransfer();
        applyStimulus(1'b0, 64'h60, 32'h0, 0, 32'h87654321, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            int dly;
            dly = int'($urandom_range(0, 6)) - 1;
            applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom, dly, $urandom,
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) begin @(posedge clk); #1; end
        checkOutput("resp_queue_drained", 64'(respQ.size()), 64'd0);
        checkOutput("req_queue_drained", 64'(reqQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
